// File: rtl/canvas_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : canvas_pkg                                                 |
// | Description : Shared defaults, write-FSM state type and FIFO entry       |
// |               format for the canvas writer.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package canvas_pkg;

  localparam int FB_WIDTH    = 320;
  localparam int FB_HEIGHT   = 180;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_CELLS    = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  color;
  } pixel_entry_t;

endpackage
`default_nettype wire

// File: rtl/canvas_writer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : canvas_writer_if                                           |
// | Description : Pixel stream in (painter side) and frame-buffer write bus  |
// |               out (BRAM side) of the canvas writer.                      |
// |   hcount_in/vcount_in/data_valid_in/color_in : painted pixel strobe      |
// |   bram_addr_out/bram_data_out/bram_we_out     : BRAM write port          |
// |   master : pixel source / BRAM observer                                  |
// |   slave  : canvas_writer                                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface canvas_writer_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic [7:0]  color_in;
  logic [15:0] bram_addr_out;
  logic [7:0]  bram_data_out;
  logic        bram_we_out;

  modport master (
    output hcount_in, vcount_in, data_valid_in, color_in,
    input  bram_addr_out, bram_data_out, bram_we_out
  );

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, color_in,
    output bram_addr_out, bram_data_out, bram_we_out
  );
endinterface
`default_nettype wire

// File: rtl/canvas_writer_pixel_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pixel_fifo                                                 |
// | Description : Synchronous first-word-fall-through FIFO. Push and pop may |
// |               happen in the same cycle; a push into a full FIFO is only  |
// |               accepted when a pop frees the slot in that cycle.          |
// |   clk_in, rst_in     : clock, synchronous active-high reset              |
// |   i_push, i_wdata    : write request and data                            |
// |   i_pop              : consume the head entry (ignored when empty)       |
// |   o_rdata            : head entry, valid whenever o_empty is low         |
// |   o_full, o_empty    : status flags                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  wire logic             clk_in,
  input  wire logic             rst_in,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/canvas_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : canvas_writer                                              |
// | Description : Turns the painter's screen-coordinate pixel stream into    |
// |               writes on a downscaled frame-buffer BRAM. Downscales and   |
// |               bounds-checks, drops consecutive duplicates, buffers in a  |
// |               FIFO and runs a full-canvas clear sweep on request.        |
// |   clk_in, rst_in : clock, synchronous active-high reset                  |
// |   clear_in       : single-cycle clear request                            |
// |   pix            : pixel stream in / BRAM write bus out                  |
// |   busy_out       : clear sweep in progress                               |
// |   overflow_out   : sticky, a pixel was lost to a full FIFO               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module canvas_writer
  import canvas_pkg::*;
#(
  parameter int         FB_WIDTH    = canvas_pkg::FB_WIDTH,
  parameter int         FB_HEIGHT   = canvas_pkg::FB_HEIGHT,
  parameter int         SCALE_SHIFT = canvas_pkg::SCALE_SHIFT,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
  input  wire logic      clk_in,
  input  wire logic      rst_in,
  input  wire logic      clear_in,
  canvas_writer_if.slave pix,
  output logic           busy_out,
  output logic           overflow_out
);

  localparam logic [15:0] c_FB_W      = 16'(FB_WIDTH);
  localparam logic [15:0] c_FB_H      = 16'(FB_HEIGHT);
  localparam logic [15:0] c_LAST_ADDR = 16'(FB_WIDTH * FB_HEIGHT - 1);

  // ---------------- S1: downscale and bounds check ----------------
  logic [15:0] w_cx;
  logic [15:0] w_cy;
  logic        w_in_range;
  logic        r_s1_valid;
  logic [15:0] r_s1_cx;
  logic [15:0] r_s1_cy;
  logic [7:0]  r_s1_color;

  assign w_cx = 16'(pix.hcount_in >> SCALE_SHIFT);
  assign w_cy = 16'(pix.vcount_in >> SCALE_SHIFT);
  // Wrapped negative painter coordinates land far above the canvas and
  // fail this compare, so they vanish here without touching overflow.
  assign w_in_range = (w_cx < c_FB_W) && (w_cy < c_FB_H);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_cx    <= '0;
      r_s1_cy    <= '0;
      r_s1_color <= '0;
    end else begin
      r_s1_valid <= pix.data_valid_in && w_in_range;
      if (pix.data_valid_in) begin
        r_s1_cx    <= w_cx;
        r_s1_cy    <= w_cy;
        r_s1_color <= pix.color_in;
      end
    end
  end

  // ---------------- S2: address, dedup, push ----------------
  pixel_entry_t w_s2_entry;
  pixel_entry_t r_last;
  logic         r_last_valid;
  logic         w_dup;
  logic         w_push_req;
  logic         w_push_ok;
  pixel_entry_t w_fifo_rdata;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic         w_pop;
  logic         w_enter_clear;
  logic         r_overflow;

  always_comb begin
    w_s2_entry       = '0;
    w_s2_entry.addr  = r_s1_cy * c_FB_W + r_s1_cx;
    w_s2_entry.color = r_s1_color;
  end

  assign w_dup      = r_last_valid && (r_last == w_s2_entry);
  assign w_push_req = r_s1_valid && !w_dup;
  assign w_push_ok  = w_push_req && (!w_fifo_full || w_pop);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_entry_t))
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push_req),
    .i_wdata (w_s2_entry),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Only pixels that actually entered the FIFO become the dedup reference.
  // Starting a sweep forgets it so a repeated pixel repaints the blank canvas.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last_valid <= 1'b0;
      r_last       <= '0;
    end else if (w_enter_clear) begin
      r_last_valid <= 1'b0;
    end else if (w_push_ok) begin
      r_last_valid <= 1'b1;
      r_last       <= w_s2_entry;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_overflow <= 1'b0;
    end else if (w_push_req && w_fifo_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // ---------------- Write FSM ----------------
  wr_state_t   r_state;
  wr_state_t   w_next_state;
  logic [15:0] r_clr_addr;
  logic        w_we;
  logic [15:0] w_addr;
  logic [7:0]  w_data;

  assign w_enter_clear = (r_state == IDLE) && clear_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // The sweep address sits at zero whenever idle, so entering CLEAR
  // always starts from the first cell.
  always_ff @(posedge clk_in) begin
    if (rst_in)                r_clr_addr <= '0;
    else if (r_state == CLEAR) r_clr_addr <= r_clr_addr + 16'd1;
    else                       r_clr_addr <= '0;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (clear_in) w_next_state = CLEAR;
      CLEAR:   if (r_clr_addr == c_LAST_ADDR) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_we   = 1'b0;
    w_addr = '0;
    w_data = '0;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        // A clear request owns its cycle; the FIFO head waits for the sweep.
        if (!clear_in && !w_fifo_empty) begin
          w_pop  = 1'b1;
          w_we   = 1'b1;
          w_addr = w_fifo_rdata.addr;
          w_data = w_fifo_rdata.color;
        end
      end
      CLEAR: begin
        w_we   = 1'b1;
        w_addr = r_clr_addr;
        w_data = CLEAR_COLOR;
      end
      default: ;
    endcase
  end

  // ---------------- Registered BRAM port ----------------
  logic        r_bram_we;
  logic [15:0] r_bram_addr;
  logic [7:0]  r_bram_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_bram_we   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_data <= '0;
    end else begin
      r_bram_we   <= w_we;
      r_bram_addr <= w_addr;
      r_bram_data <= w_data;
    end
  end

  assign pix.bram_we_out   = r_bram_we;
  assign pix.bram_addr_out = r_bram_addr;
  assign pix.bram_data_out = r_bram_data;
  assign busy_out          = (r_state == CLEAR);
  assign overflow_out      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_canvas_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_canvas_writer                                           |
// | Description : Directed bench for canvas_writer with a write scoreboard.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_canvas_writer;
  import canvas_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic clear_in;
  logic busy_out;
  logic overflow_out;

  canvas_writer_if pix ();

  canvas_writer #(
    .FB_WIDTH    (320),
    .FB_HEIGHT   (180),
    .SCALE_SHIFT (2),
    .FIFO_DEPTH  (8),
    .CLEAR_COLOR (8'h00)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .clear_in     (clear_in),
    .pix          (pix),
    .busy_out     (busy_out),
    .overflow_out (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  int n_busy = 0;
  int last_write_cyc = 0;
  pixel_entry_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest expectation.
  always @(negedge clk_in) begin
    if (busy_out === 1'b1) n_busy++;
    if (pix.bram_we_out === 1'b1) begin
      n_writes++;
      last_write_cyc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_write: observed addr %0d data %0h expected no write",
                 pix.bram_addr_out, pix.bram_data_out);
        end
      end else begin
        pixel_entry_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(pix.bram_addr_out), 32'(e.addr));
        check("wr_data", 32'(pix.bram_data_out), 32'(e.color));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_px(input int h, input int v, input logic [7:0] c);
    pix.hcount_in     = 11'(h);
    pix.vcount_in     = 10'(v);
    pix.color_in      = c;
    pix.data_valid_in = 1'b1;
    tick();
  endtask

  task automatic expect_wr(input int addr, input logic [7:0] c);
    pixel_entry_t e;
    e.addr  = 16'(addr);
    e.color = c;
    sb.push_back(e);
  endtask

  initial begin
    int d_cyc;
    int w0;
    int nb0;
    int c_cyc;
    logic found;

    rst_in = 1'b1;
    clear_in = 1'b0;
    pix.hcount_in = '0;
    pix.vcount_in = '0;
    pix.color_in = '0;
    pix.data_valid_in = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_we", 32'(pix.bram_we_out), 32'd0);
    check("rst_addr", 32'(pix.bram_addr_out), 32'd0);
    check("rst_data", 32'(pix.bram_data_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    rst_in = 1'b0;
    tick();

    // Single pixel: 40>>2=10, 100>>2=25 -> 3225, write three cycles later
    w0 = n_writes;
    d_cyc = cyc;
    expect_wr(3225, 8'h5A);
    drive_px(100, 40, 8'h5A);
    pix.data_valid_in = 1'b0;
    repeat (6) tick();
    check("single_latency", 32'(last_write_cyc - d_cyc), 32'd3);
    check("single_count", 32'(n_writes - w0), 32'd1);

    // Painter-style repeats from a fresh dedup state
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    w0 = n_writes;
    expect_wr(3225, 8'h5A);
    expect_wr(3226, 8'h5A);
    repeat (4) drive_px(100, 40, 8'h5A);
    drive_px(101, 40, 8'h5A);
    drive_px(104, 40, 8'h5A);
    pix.data_valid_in = 1'b0;
    repeat (8) tick();
    check("dedup_count", 32'(n_writes - w0), 32'd2);

    // Out of range: wrapped x and y just past the last row
    w0 = n_writes;
    drive_px(2040, 40, 8'h11);
    drive_px(100, 720, 8'h22);
    pix.data_valid_in = 1'b0;
    repeat (6) tick();
    check("oor_count", 32'(n_writes - w0), 32'd0);
    check("oor_ovf", 32'(overflow_out), 32'd0);

    // Last in-range cell: 179*320+319
    expect_wr(57599, 8'h77);
    drive_px(1279, 719, 8'h77);
    pix.data_valid_in = 1'b0;
    repeat (6) tick();
    check("corner_count", 32'(n_writes - w0), 32'd1);

    // Full clear sweep with 9 pixels injected while it runs
    for (int i = 0; i < 57600; i++) expect_wr(i, 8'h00);
    check("busy_before", 32'(busy_out), 32'd0);
    nb0 = n_busy;
    c_cyc = cyc;
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    check("busy_rise", 32'(busy_out), 32'd1);
    repeat (20) tick();
    clear_in = 1'b1;   // ignored mid-sweep
    tick();
    clear_in = 1'b0;
    // Same as the last pixel before the clear: must be written again
    expect_wr(57599, 8'h77);
    drive_px(1279, 719, 8'h77);
    for (int i = 0; i < 7; i++) begin
      expect_wr(640 + i, 8'(8'h80 + i));
      drive_px(4 * i, 8, 8'(8'h80 + i));
    end
    pix.data_valid_in = 1'b0;
    repeat (3) tick();
    check("ovf_at_full", 32'(overflow_out), 32'd0);
    drive_px(28, 8, 8'h87);   // ninth: FIFO full, dropped
    pix.data_valid_in = 1'b0;
    repeat (3) tick();
    check("ovf_set", 32'(overflow_out), 32'd1);
    for (int i = 0; i < 60000 && busy_out; i++) tick();
    check("sweep_done", 32'(busy_out), 32'd0);
    repeat (15) tick();
    check("busy_cycles", 32'(n_busy - nb0), 32'd57600);
    check("queued_after_sweep", 32'(last_write_cyc - c_cyc), 32'd57609);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("ovf_sticky", 32'(overflow_out), 32'd1);

    // Reset mid-sweep at address 1000 with pixels queued
    for (int i = 0; i <= 1000; i++) expect_wr(i, 8'h00);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    for (int i = 0; i < 4; i++) drive_px(4 * i, 100, 8'h40);
    pix.data_valid_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (pix.bram_we_out && pix.bram_addr_out == 16'd1000) found = 1'b1;
    end
    check("reached_1000", 32'(found), 32'd1);
    rst_in = 1'b1;
    tick();
    check("abort_we", 32'(pix.bram_we_out), 32'd0);
    check("abort_addr", 32'(pix.bram_addr_out), 32'd0);
    check("abort_data", 32'(pix.bram_data_out), 32'd0);
    check("abort_busy", 32'(busy_out), 32'd0);
    check("abort_ovf", 32'(overflow_out), 32'd0);
    rst_in = 1'b0;
    w0 = n_writes;
    repeat (20) tick();
    check("abort_fifo_empty", 32'(n_writes - w0), 32'd0);
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/canvas_writer.md
# canvas_writer

Downstream consumer of the circle painter's pixel stream. It takes painted screen coordinates (hcount/vcount with a valid strobe) and turns them into write transactions on a downscaled single-port frame-buffer BRAM. It downscales and bounds-checks each coordinate, drops duplicate consecutive writes, and buffers pixels in a small FIFO. It also runs a full-canvas clear sweep on request. The painter has no backpressure, so this block must accept an input every cycle.

## Interface

Parameters:
- FB_WIDTH, 320: canvas width in cells.
- FB_HEIGHT, 180: canvas height in cells.
- SCALE_SHIFT, 2: screen-to-cell downscale; cell = screen coordinate >> SCALE_SHIFT.
- FIFO_DEPTH, 8: pixel FIFO entries; must be a power of 2.
- CLEAR_COLOR, 8'h00: value written by the clear sweep.

Ports:
- clk_in, input, 1: system clock; the only clock.
- rst_in, input, 1: reset, synchronous, active-high.
- hcount_in, input, 11: painted pixel x (screen).
- vcount_in, input, 10: painted pixel y (screen).
- data_valid_in, input, 1: pixel strobe, one pixel per high cycle.
- color_in, input, 8: color, sampled with data_valid_in.
- clear_in, input, 1: single-cycle request to clear the canvas.
- bram_addr_out, output, 16: frame-buffer write address.
- bram_data_out, output, 8: frame-buffer write data.
- bram_we_out, output, 1: write enable.
- busy_out, output, 1: high while the clear sweep runs.
- overflow_out, output, 1: sticky flag; a pixel was dropped because the FIFO was full.

## Operation

- S1 (registered): sample the inputs when data_valid_in is high.
  - Compute cx = hcount_in >> SCALE_SHIFT and cy = vcount_in >> SCALE_SHIFT.
  - Mark the pixel out of range if cx >= FB_WIDTH or cy >= FB_HEIGHT. This covers the painter's wrapped negative coordinates, e.g. hcount 2040.
  - Out-of-range pixels are discarded silently; they do not set overflow_out.
- S2 (registered): addr = cy*FB_WIDTH + cx, computed as a 16-bit unsigned result.
  - Dedup: if {addr,color} equals the last pushed {addr,color} and last_valid=1, drop the pixel.
  - Otherwise push {addr,color} into the FIFO and update the last-pushed register.
- FIFO full on push: drop the pixel and set overflow_out. overflow_out clears only on rst_in.
- Write FSM states: IDLE and CLEAR.
  - IDLE, clear_in=1: go to CLEAR and set clr_addr=0. clear_in takes the cycle even if the FIFO is non-empty.
  - IDLE, FIFO non-empty, no clear: pop one entry per cycle and drive bram_we_out=1 with that entry's addr and data.
  - CLEAR: every cycle write clr_addr with CLEAR_COLOR and increment clr_addr. After address FB_WIDTH*FB_HEIGHT-1 is written, return to IDLE.
  - CLEAR does not drain the FIFO. The S1/S2 pipeline keeps accepting input and pushing.
  - clear_in during CLEAR is ignored.
- Entering CLEAR clears last_valid, so a pixel repeated after the clear is written again.
- Pixels queued during CLEAR are written after the sweep finishes, so they land on the cleared canvas.

## Timing

- Reset values: bram_addr_out=0, bram_data_out=0, bram_we_out=0, busy_out=0, overflow_out=0. Also on reset: FIFO empty, last_valid=0, state IDLE, pipeline valids 0.
- rst_in mid-sweep or mid-stream aborts immediately, and all FIFO contents are discarded.
- Latency: a pixel with data_valid_in at cycle N, with an empty FIFO and state IDLE, produces bram_we_out=1 at cycle N+3 (S1 at N+1, push at N+2, write at N+3).
- Throughput: one write per cycle in IDLE.
- busy_out rises the cycle after clear_in is sampled in IDLE. It stays high for exactly FB_WIDTH*FB_HEIGHT cycles, one write per cycle.
- Simultaneous push and pop on a full FIFO is allowed: the pop frees the slot, so there is no overflow.
- bram_we_out is never high without a valid write, and there is never more than one write per cycle.

## Structure

- canvas_pkg holds:
  - the FB_WIDTH/FB_HEIGHT/SCALE_SHIFT defaults;
  - localparam FB_CELLS = FB_WIDTH*FB_HEIGHT;
  - the write-FSM enum {IDLE, CLEAR};
  - the packed pixel-entry struct {addr[15:0], color[7:0]}.
- Sub-module pixel_fifo: a synchronous FIFO with full/empty flags, same-cycle push and pop, and first-word-fall-through output. The rest of the logic stays in canvas_writer.

## Test plan

- Single pixel hcount=100, vcount=40, color=8'h5A, FIFO empty → at N+3, addr=10*320+25=3225, data=8'h5A, one-cycle we.
- Painter-style repeat: the same (100,40,5A) held for 4 cycles, then (101,40) and (104,40) → writes to 3225 (101,40 maps to the same cell, so it is deduped) and 3226 only.
- Out of range: (2040,40) and (100,720) → no write and overflow_out=0.
- clear_in while idle → busy_out high for 57600 cycles; writes at addr 0..57599 with data 00; then IDLE.
- Pixels injected during the clear:
  - 3 distinct pixels → written in order right after the last clear address.
  - 9 distinct pixels → overflow_out=1, the first 8 are written, and the flag stays set until rst_in.
- rst_in asserted mid-clear at addr 1000 → next cycle all outputs are 0, busy_out=0, and the FIFO is empty.
